// File: rtl/fetch_queue_if.sv
// Bus between the instruction prefetch queue, the fetch-side TileLink master and decode.
// master = the queue itself, slave = the bus/decode environment around it.
interface fetch_queue_if #(
   parameter int XLEN = 64
);
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            rsp_valid;
   logic [31:0]     rsp_data;
   logic            flush;
   logic [XLEN-1:0] flush_pc;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_inst;
   logic [XLEN-1:0] out_pc;
   logic            out_comp;

   modport master (
      output req_valid, req_addr, out_valid, out_inst, out_pc, out_comp,
      input  req_ready, rsp_valid, rsp_data, flush, flush_pc, out_ready
   );

   modport slave (
      input  req_valid, req_addr, out_valid, out_inst, out_pc, out_comp,
      output req_ready, rsp_valid, rsp_data, flush, flush_pc, out_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: keeps up to DEPTH words requested or buffered, realigns
// 16/32-bit instructions across word boundaries and hands decode one instruction per cycle.
module fetch_queue #(
   parameter int              XLEN     = 64,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
   input logic         clk,
   input logic         rst_n,
   fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 1;

   logic [31:0]     mem_q [DEPTH];
   logic [CW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [XLEN-1:0] fetchAddr_q, fetchAddr_d;
   logic [XLEN-1:0] headPc_q, headPc_d;
   logic            headOff_q, headOff_d;
   logic            active_q;

   logic [PW-1:0]   rdIdx, nextIdx;
   logic [31:0]     headWord;
   logic [15:0]     nextHalf, hw0;
   logic            isComp, instReady, outValid;
   logic [31:0]     rawInst;
   logic [SW-1:0]   inFlight;
   logic            reqValid, reqFire, rspFire, rspDrop, push, pop, retire;

   assign rdIdx    = rdPtr_q[PW-1:0];
   assign nextIdx  = rdIdx + PW'(1);
   assign headWord = mem_q[rdIdx];
   assign nextHalf = mem_q[nextIdx][15:0];
   assign hw0      = headOff_q ? headWord[31:16] : headWord[15:0];
   assign isComp   = (hw0[1:0] != 2'b11);

   // A 32-bit instruction starting in the upper half needs the following word too.
   assign instReady = isComp ? (count_q != '0)
                    : (headOff_q ? (count_q >= CW'(2)) : (count_q != '0));
   assign outValid  = instReady && !bus.flush;
   assign rawInst   = isComp ? {16'h0, hw0}
                    : (headOff_q ? {nextHalf, headWord[31:16]} : headWord);

   assign bus.out_valid = outValid;
   assign bus.out_inst  = outValid ? rawInst : 32'h0;
   assign bus.out_comp  = outValid && isComp;
   assign bus.out_pc    = headPc_q;

   // Buffered words plus in-flight requests never exceed DEPTH, so responses always fit.
   assign inFlight      = {1'b0, count_q} + {1'b0, outstanding_q};
   assign reqValid      = active_q && !bus.flush && (inFlight < SW'(DEPTH));
   assign bus.req_valid = reqValid;
   assign bus.req_addr  = fetchAddr_q;

   assign reqFire = reqValid && bus.req_ready;
   assign rspFire = bus.rsp_valid && (outstanding_q != '0);
   assign rspDrop = rspFire && (discard_q != '0);
   assign push    = rspFire && (discard_q == '0) && !bus.flush;
   assign pop     = outValid && bus.out_ready;
   assign retire  = pop && (headOff_q || !isComp);

   // Next-state for pointers, counters and PC tracking; a redirect overrides everything.
   always_comb begin
      rdPtr_d       = rdPtr_q;
      wrPtr_d       = wrPtr_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      fetchAddr_d   = fetchAddr_q;
      headPc_d      = headPc_q;
      headOff_d     = headOff_q;
      if (bus.flush) begin
         rdPtr_d       = wrPtr_q;
         count_d       = '0;
         outstanding_d = outstanding_q - (rspFire ? CW'(1) : CW'(0));
         discard_d     = outstanding_q - (rspFire ? CW'(1) : CW'(0));
         fetchAddr_d   = {bus.flush_pc[XLEN-1:2], 2'b00};
         headPc_d      = bus.flush_pc;
         headOff_d     = bus.flush_pc[1];
      end else begin
         if (push) wrPtr_d = wrPtr_q + CW'(1);
         if (retire) rdPtr_d = rdPtr_q + CW'(1);
         if (push && !retire) count_d = count_q + CW'(1);
         else if (!push && retire) count_d = count_q - CW'(1);
         if (reqFire && !rspFire) outstanding_d = outstanding_q + CW'(1);
         else if (!reqFire && rspFire) outstanding_d = outstanding_q - CW'(1);
         if (rspDrop) discard_d = discard_q - CW'(1);
         if (reqFire) fetchAddr_d = fetchAddr_q + XLEN'(4);
         if (pop) begin
            headPc_d = headPc_q + (isComp ? XLEN'(2) : XLEN'(4));
            if (isComp) headOff_d = !headOff_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr_q       <= '0;
         wrPtr_q       <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         fetchAddr_q   <= {RESET_PC[XLEN-1:2], 2'b00};
         headPc_q      <= RESET_PC;
         headOff_q     <= RESET_PC[1];
         active_q      <= 1'b0;
      end else begin
         rdPtr_q       <= rdPtr_d;
         wrPtr_q       <= wrPtr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         fetchAddr_q   <= fetchAddr_d;
         headPc_q      <= headPc_d;
         headOff_q     <= headOff_d;
         active_q      <= 1'b1;
      end
   end

   // Word storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q[PW-1:0]] <= bus.rsp_data;
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: table of instruction streams checked through a scoreboard,
// plus hand-written redirect, stall and reset sequences.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic        comp;
   } exp_t;

   typedef struct {
      logic [63:0]      startPc;
      logic [3:0][31:0] words;
      int               nExp;
      logic [3:0][31:0] expInst;
      logic [3:0]       expComp;
      logic [3:0][7:0]  expOff;
      int               prime;
      int               stallCycles;
   } vec_t;

   logic clk;
   logic rst_n;
   fetch_queue_if #(.XLEN(64)) bus ();

   fetch_queue #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(64'h8000_0000)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t        vecs [5];
   exp_t        sb [$];
   logic [63:0] pend [$];
   logic [31:0] memArr [logic [63:0]];
   int          checks = 0;
   int          failures = 0;
   logic        rspEn, stall, forceReady, flushNow;
   logic [63:0] flushPcNow, expFetch;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] rdMem(input logic [63:0] a);
      return memArr.exists(a) ? memArr[a] : 32'h0;
   endfunction

   // One clock cycle: drive at the falling edge, sample 1ns later, clock rises afterwards.
   task automatic applyStimulus();
      logic [63:0] a;
      exp_t e;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = 32'h0;
      if (rspEn && pend.size() > 0) begin
         a = pend.pop_front();
         bus.rsp_valid = 1'b1;
         bus.rsp_data  = rdMem(a);
      end
      bus.req_ready = 1'b1;
      bus.flush     = flushNow;
      bus.flush_pc  = flushPcNow;
      bus.out_ready = forceReady || (!stall && sb.size() > 0);
      #1;
      if (bus.flush) begin
         checkOutput("flush out_valid", 64'(bus.out_valid), 64'd0);
         checkOutput("flush req_valid", 64'(bus.req_valid), 64'd0);
         expFetch = flushPcNow & ~64'h3;
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            checkOutput("req_addr", bus.req_addr, expFetch);
            expFetch = expFetch + 64'd4;
            pend.push_back(bus.req_addr);
            checkOutput("outstanding<=DEPTH", 64'(pend.size() <= DEPTH), 64'd1);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected pop", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("out_inst", 64'(bus.out_inst), 64'(e.inst));
               checkOutput("out_pc", bus.out_pc, e.pc);
               checkOutput("out_comp", 64'(bus.out_comp), 64'(e.comp));
            end
         end
      end
   endtask

   task automatic setVec(input int i, input logic [63:0] pc,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                         input int n,
                         input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] i3,
                         input logic [3:0] comps,
                         input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2, input logic [7:0] o3,
                         input int prime, input int stallC);
      vecs[i].startPc     = pc;
      vecs[i].words[0]    = w0;
      vecs[i].words[1]    = w1;
      vecs[i].words[2]    = w2;
      vecs[i].words[3]    = w3;
      vecs[i].nExp        = n;
      vecs[i].expInst[0]  = i0;
      vecs[i].expInst[1]  = i1;
      vecs[i].expInst[2]  = i2;
      vecs[i].expInst[3]  = i3;
      vecs[i].expComp     = comps;
      vecs[i].expOff[0]   = o0;
      vecs[i].expOff[1]   = o1;
      vecs[i].expOff[2]   = o2;
      vecs[i].expOff[3]   = o3;
      vecs[i].prime       = prime;
      vecs[i].stallCycles = stallC;
   endtask

   task automatic drainBus();
      rspEn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (pend.size() == 0) break;
         applyStimulus();
      end
      checkOutput("bus drained", 64'(pend.size()), 64'd0);
   endtask

   // Leaves three requests in flight (coincident mode: one word buffered and visible too).
   task automatic primeOutstanding(input logic [63:0] a, input bit coincident);
      drainBus();
      memArr[a] = 32'h0000_4501;
      rspEn      = 1'b0;
      flushNow   = 1'b1;
      flushPcNow = a;
      applyStimulus();
      flushNow = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("prime outstanding", 64'(pend.size()), 64'd3);
      if (coincident) begin
         rspEn = 1'b1;
         applyStimulus();
         rspEn = 1'b0;
         applyStimulus();
         checkOutput("pre-flush out_valid", 64'(bus.out_valid), 64'd1);
         checkOutput("pre-flush out_inst", 64'(bus.out_inst), 64'h4501);
         checkOutput("pre-flush out_pc", bus.out_pc, a);
         checkOutput("pre-flush out_comp", 64'(bus.out_comp), 64'd1);
      end
   endtask

   task automatic runVector(input int i);
      logic [63:0] base;
      base = vecs[i].startPc & ~64'h3;
      if (vecs[i].prime != 0)
         primeOutstanding(64'h8000_4000 + 64'(i) * 64'h100, vecs[i].prime == 2);
      for (int k = 0; k < 4; k++) memArr[base + 64'(4 * k)] = vecs[i].words[k];
      for (int k = 0; k < vecs[i].nExp; k++)
         sb.push_back('{inst: vecs[i].expInst[k],
                        pc:   vecs[i].startPc + 64'(vecs[i].expOff[k]),
                        comp: vecs[i].expComp[k]});
      if (i != 0) begin
         flushNow   = 1'b1;
         flushPcNow = vecs[i].startPc;
         forceReady = (vecs[i].prime == 2);
         rspEn      = (vecs[i].prime != 1);
         applyStimulus();
         flushNow   = 1'b0;
         forceReady = 1'b0;
         rspEn      = 1'b1;
         applyStimulus();
         checkOutput("req_valid after flush", 64'(bus.req_valid), 64'd1);
         checkOutput("req_addr after flush", bus.req_addr, base);
      end
      if (vecs[i].stallCycles > 0) begin
         stall = 1'b1;
         repeat (vecs[i].stallCycles) applyStimulus();
         checkOutput("stall req_valid", 64'(bus.req_valid), 64'd0);
         checkOutput("stall bus idle", 64'(pend.size()), 64'd0);
         stall = 1'b0;
      end
      for (int k = 0; k < 100; k++) begin
         if (sb.size() == 0) break;
         applyStimulus();
      end
      checkOutput("stream drained", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      setVec(0, 64'h8000_0000, 32'h0001_4501, 32'h0000_0513, 32'h0, 32'h0,
             3, 32'h0000_4501, 32'h0000_0001, 32'h0000_0513, 32'h0, 4'b0011, 8'd0, 8'd2, 8'd4, 8'd0, 0, 0);
      setVec(1, 64'h8000_1000, 32'h0513_4501, 32'h0, 32'h0, 32'h0,
             2, 32'h0000_4501, 32'h0000_0513, 32'h0, 32'h0, 4'b0001, 8'd0, 8'd2, 8'd0, 8'd0, 0, 0);
      setVec(2, 64'h8000_0102, 32'h4505_FFFF, 32'h0613_0585, 32'hABCD_0000, 32'h0,
             3, 32'h0000_4505, 32'h0000_0585, 32'h0000_0613, 32'h0, 4'b0011, 8'd0, 8'd2, 8'd4, 8'd0, 1, 0);
      setVec(3, 64'h8000_2000, 32'h00A0_0093, 32'h0010_8113, 32'h0021_0193, 32'h0031_8213,
             4, 32'h00A0_0093, 32'h0010_8113, 32'h0021_0193, 32'h0031_8213, 4'b0000, 8'd0, 8'd4, 8'd8, 8'd12, 0, 10);
      setVec(4, 64'h8000_3006, 32'h0513_0000, 32'h0001_0000, 32'h0, 32'h0,
             2, 32'h0000_0513, 32'h0000_0001, 32'h0, 32'h0, 4'b0010, 8'd0, 8'd4, 8'd0, 8'd0, 2, 0);

      rst_n         = 1'b0;
      rspEn         = 1'b1;
      stall         = 1'b0;
      forceReady    = 1'b0;
      flushNow      = 1'b0;
      flushPcNow    = 64'h0;
      expFetch      = 64'h8000_0000;
      bus.req_ready = 1'b1;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = 32'h0;
      bus.flush     = 1'b0;
      bus.flush_pc  = 64'h0;
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset req_valid", 64'(bus.req_valid), 64'd0);
      checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset out_inst", 64'(bus.out_inst), 64'd0);
      checkOutput("reset out_comp", 64'(bus.out_comp), 64'd0);
      checkOutput("reset req_addr", bus.req_addr, 64'h8000_0000);
      checkOutput("reset out_pc", bus.out_pc, 64'h8000_0000);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("release req_valid", 64'(bus.req_valid), 64'd0);
      applyStimulus();
      checkOutput("first req_valid", 64'(bus.req_valid), 64'd1);

      for (int i = 0; i < 5; i++) runVector(i);

      // Asynchronous reset while the queue holds data.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("midreset req_valid", 64'(bus.req_valid), 64'd0);
      checkOutput("midreset out_pc", bus.out_pc, 64'h8000_0000);
      checkOutput("midreset req_addr", bus.req_addr, 64'h8000_0000);
      pend.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
